// File: rtl/reservation_station_pkg.sv
// Shared CPU definitions: widths, opcode constants, NON_DEP tag, entry types
// and the CDB operand-capture helper used by the reservation station.
package cpu_defs;
    localparam int ADDR_WIDTH   = 32;
    localparam int RoB_WIDTH    = 8;
    localparam int EX_RoB_WIDTH = 9;
    localparam logic [EX_RoB_WIDTH-1:0] NON_DEP = EX_RoB_WIDTH'(1 << RoB_WIDTH);

    localparam logic [6:0] lui  = 7'd1,  auipc = 7'd2,  jal   = 7'd3,  jalr  = 7'd4;
    localparam logic [6:0] beq  = 7'd5,  bne   = 7'd6,  blt   = 7'd7,  bge   = 7'd8;
    localparam logic [6:0] bltu = 7'd9,  bgeu  = 7'd10, lb    = 7'd11, lh    = 7'd12;
    localparam logic [6:0] lw   = 7'd13, lbu   = 7'd14, lhu   = 7'd15, sb    = 7'd16;
    localparam logic [6:0] sh   = 7'd17, sw    = 7'd18, addi  = 7'd19, slti  = 7'd20;
    localparam logic [6:0] sltiu = 7'd21, xori = 7'd22, ori   = 7'd23, andi  = 7'd24;
    localparam logic [6:0] slli = 7'd25, srli  = 7'd26, srai  = 7'd27, add   = 7'd28;
    localparam logic [6:0] sub  = 7'd29, sll   = 7'd30, slt   = 7'd31, sltu  = 7'd32;
    localparam logic [6:0] xorr = 7'd33, srl   = 7'd34, sra   = 7'd35, orr   = 7'd36;
    localparam logic [6:0] andd = 7'd37;

    typedef struct packed {
        logic [EX_RoB_WIDTH-1:0] q;
        logic [31:0]             v;
    } operand_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [6:0]            opcode;
        operand_t              j;
        operand_t              k;
        logic [31:0]           imm;
        logic [RoB_WIDTH-1:0]  rob;
    } rs_entry_t;

    function automatic logic is_lsb_op(input logic [6:0] op);
        return (op >= lb) && (op <= sw);
    endfunction

    // Capture a broadcast value for a pending operand; RS port beats LSB port.
    function automatic operand_t cdb_resolve(
        input operand_t             o,
        input logic                 rs_en,
        input logic [RoB_WIDTH-1:0] rs_idx,
        input logic [31:0]          rs_val,
        input logic                 lsb_en,
        input logic [RoB_WIDTH-1:0] lsb_idx,
        input logic [31:0]          lsb_val);
        operand_t r;
        r = o;
        if (rs_en && o.q == EX_RoB_WIDTH'(rs_idx)) begin
            r.q = NON_DEP;
            r.v = rs_val;
        end else if (lsb_en && o.q == EX_RoB_WIDTH'(lsb_idx)) begin
            r.q = NON_DEP;
            r.v = lsb_val;
        end
        return r;
    endfunction
endpackage

// File: rtl/reservation_station_if.sv
// Dispatcher / CDB / RoB / ALU bundle around the reservation station.
// master = environment side, slave = reservation station side.
interface reservation_station_if;
    import cpu_defs::*;
    logic                    DPRS_en;
    logic [ADDR_WIDTH-1:0]   DPRS_pc;
    logic [6:0]              DPRS_opcode;
    logic [31:0]             DPRS_Vj, DPRS_Vk, DPRS_imm;
    logic [EX_RoB_WIDTH-1:0] DPRS_Qj, DPRS_Qk;
    logic [RoB_WIDTH-1:0]    DPRS_RoB_index;
    logic                    CDBRS_RS_en, CDBRS_LSB_en;
    logic [RoB_WIDTH-1:0]    CDBRS_RS_RoB_index, CDBRS_LSB_RoB_index;
    logic [31:0]             CDBRS_RS_value, CDBRS_LSB_value;
    logic                    RoBRS_pre_judge;
    logic                    RSDP_full;
    logic                    RSALU_en;
    logic [ADDR_WIDTH-1:0]   RSALU_pc;
    logic [6:0]              RSALU_opcode;
    logic [31:0]             RSALU_Vj, RSALU_Vk, RSALU_imm;
    logic [RoB_WIDTH-1:0]    RSALU_RoB_index;

    modport master (
        output DPRS_en, DPRS_pc, DPRS_opcode, DPRS_Vj, DPRS_Vk, DPRS_imm,
               DPRS_Qj, DPRS_Qk, DPRS_RoB_index,
               CDBRS_RS_en, CDBRS_LSB_en, CDBRS_RS_RoB_index, CDBRS_LSB_RoB_index,
               CDBRS_RS_value, CDBRS_LSB_value, RoBRS_pre_judge,
        input  RSDP_full, RSALU_en, RSALU_pc, RSALU_opcode, RSALU_Vj, RSALU_Vk,
               RSALU_imm, RSALU_RoB_index
    );
    modport slave (
        input  DPRS_en, DPRS_pc, DPRS_opcode, DPRS_Vj, DPRS_Vk, DPRS_imm,
               DPRS_Qj, DPRS_Qk, DPRS_RoB_index,
               CDBRS_RS_en, CDBRS_LSB_en, CDBRS_RS_RoB_index, CDBRS_LSB_RoB_index,
               CDBRS_RS_value, CDBRS_LSB_value, RoBRS_pre_judge,
        output RSDP_full, RSALU_en, RSALU_pc, RSALU_opcode, RSALU_Vj, RSALU_Vk,
               RSALU_imm, RSALU_RoB_index
    );
endinterface

// File: rtl/reservation_station_rs_select.sv
// Lowest-index priority picker: request vector in, index + found flag out.
module rs_select #(
    parameter int N = 16
) (
    input  logic [N-1:0]         i_req,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_found
);
    localparam int W = $clog2(N);

    // Scan from the top so the lowest set request is the last to win
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = W'(i);
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reservation_station.sv
// Reservation station for ALU/branch/jump ops: holds entries until both
// operands are valid (snooping RS and LSB CDB ports), issues one per cycle.
// Build option: RS_AGE_ORDER_EN -> oldest-ready issue via an age matrix;
// otherwise lowest-index ready entry issues.
module reservation_station
    import cpu_defs::*;
#(
    parameter int RS_SIZE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    reservation_station_if.slave bus
);
    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] r_busy;
    rs_entry_t          r_ent [RS_SIZE];
    logic               r_alu_en;
    rs_entry_t          r_alu;

    logic [RS_SIZE-1:0] w_ready, w_issue_req;
    operand_t           w_nj [RS_SIZE];
    operand_t           w_nk [RS_SIZE];
    rs_entry_t          w_ins;
    logic [IW-1:0]      w_free_idx, w_iss_idx;
    logic               w_free_found, w_iss_found;
    logic [IW:0]        w_cnt;
    logic               w_flush;

    assign w_flush = rst || !bus.RoBRS_pre_judge;

    // Per-entry snoop result and readiness (readiness uses registered tags only)
    for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
        assign w_nj[g] = cdb_resolve(r_ent[g].j, bus.CDBRS_RS_en, bus.CDBRS_RS_RoB_index,
                                     bus.CDBRS_RS_value, bus.CDBRS_LSB_en,
                                     bus.CDBRS_LSB_RoB_index, bus.CDBRS_LSB_value);
        assign w_nk[g] = cdb_resolve(r_ent[g].k, bus.CDBRS_RS_en, bus.CDBRS_RS_RoB_index,
                                     bus.CDBRS_RS_value, bus.CDBRS_LSB_en,
                                     bus.CDBRS_LSB_RoB_index, bus.CDBRS_LSB_value);
        assign w_ready[g] = r_busy[g] && (r_ent[g].j.q == NON_DEP) && (r_ent[g].k.q == NON_DEP);
    end

    // Incoming entry, with same-cycle CDB capture applied to its operands
    always_comb begin
        w_ins.pc     = bus.DPRS_pc;
        w_ins.opcode = bus.DPRS_opcode;
        w_ins.imm    = bus.DPRS_imm;
        w_ins.rob    = bus.DPRS_RoB_index;
        w_ins.j = cdb_resolve(operand_t'{q: bus.DPRS_Qj, v: bus.DPRS_Vj},
                              bus.CDBRS_RS_en, bus.CDBRS_RS_RoB_index, bus.CDBRS_RS_value,
                              bus.CDBRS_LSB_en, bus.CDBRS_LSB_RoB_index, bus.CDBRS_LSB_value);
        w_ins.k = cdb_resolve(operand_t'{q: bus.DPRS_Qk, v: bus.DPRS_Vk},
                              bus.CDBRS_RS_en, bus.CDBRS_RS_RoB_index, bus.CDBRS_RS_value,
                              bus.CDBRS_LSB_en, bus.CDBRS_LSB_RoB_index, bus.CDBRS_LSB_value);
    end

`ifdef RS_AGE_ORDER_EN
    // r_older[i][j] = 1 means entry j was inserted before entry i
    logic [RS_SIZE-1:0] r_older [RS_SIZE];

    // Age matrix: a new entry is younger than everything busy; clearing its
    // column drops stale "older than" claims left from its previous life
    always_ff @(posedge clk) begin
        if (w_flush) begin
            for (int i = 0; i < RS_SIZE; i++) r_older[i] <= '0;
        end else if (rdy && bus.DPRS_en && w_free_found) begin
            for (int k = 0; k < RS_SIZE; k++) r_older[k][w_free_idx] <= 1'b0;
            r_older[w_free_idx] <= r_busy;
        end
    end

    // Only a ready entry with no older ready entry may request issue
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++)
            w_issue_req[i] = w_ready[i] && ((w_ready & r_older[i]) == '0);
    end
`else
    assign w_issue_req = w_ready;
`endif

    rs_select #(.N(RS_SIZE)) u_free_sel (
        .i_req   (~r_busy),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    rs_select #(.N(RS_SIZE)) u_iss_sel (
        .i_req   (w_issue_req),
        .o_idx   (w_iss_idx),
        .o_found (w_iss_found)
    );

    // Busy popcount for the full flag (one slot reserved for in-flight dispatch)
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) w_cnt = w_cnt + (IW+1)'(r_busy[i]);
    end
    assign bus.RSDP_full = (w_cnt >= (IW+1)'(RS_SIZE - 1));

    // Entry state and issue register: flush beats rdy hold beats normal work
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_busy   <= '0;
            r_alu_en <= 1'b0;
            r_alu    <= '0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    r_ent[i].j <= w_nj[i];
                    r_ent[i].k <= w_nk[i];
                end
            end
            r_alu_en <= w_iss_found;
            if (w_iss_found) begin
                r_alu             <= r_ent[w_iss_idx];
                r_busy[w_iss_idx] <= 1'b0;
            end
            if (bus.DPRS_en && w_free_found) begin
                r_busy[w_free_idx] <= 1'b1;
                r_ent[w_free_idx]  <= w_ins;
            end
        end
    end

    // Dispatcher must honour RSDP_full; an insert with no free slot is dropped
    always_ff @(posedge clk) begin
        if (!w_flush && rdy && bus.DPRS_en) assert (w_free_found);
    end

    assign bus.RSALU_en        = r_alu_en;
    assign bus.RSALU_pc        = r_alu.pc;
    assign bus.RSALU_opcode    = r_alu.opcode;
    assign bus.RSALU_Vj        = r_alu.j.v;
    assign bus.RSALU_Vk        = r_alu.k.v;
    assign bus.RSALU_imm       = r_alu.imm;
    assign bus.RSALU_RoB_index = r_alu.rob;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: reset, ready insert, dependency
// wakeup, same-cycle capture, port precedence, fill/drain, flush, rdy hold
// and issue order (age order when RS_AGE_ORDER_EN is defined).
module tb_reservation_station;
    import cpu_defs::*;

    logic clk, rst, rdy;
    int   n_checks = 0;
    int   n_errors = 0;
    localparam logic [8:0] ND = 9'h100;

    reservation_station_if bus ();

    reservation_station #(.RS_SIZE(16)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.DPRS_en      = 1'b0;
        bus.CDBRS_RS_en  = 1'b0;
        bus.CDBRS_LSB_en = 1'b0;
    endtask

    task automatic ins(input logic [31:0] pc, input logic [6:0] op, input logic [31:0] vj,
                       input logic [31:0] vk, input logic [8:0] qj, input logic [8:0] qk,
                       input logic [31:0] imm, input logic [7:0] rob);
        bus.DPRS_en        = 1'b1;
        bus.DPRS_pc        = pc;
        bus.DPRS_opcode    = op;
        bus.DPRS_Vj        = vj;
        bus.DPRS_Vk        = vk;
        bus.DPRS_Qj        = qj;
        bus.DPRS_Qk        = qk;
        bus.DPRS_imm       = imm;
        bus.DPRS_RoB_index = rob;
    endtask

    task automatic rs_cdb(input logic [7:0] idx, input logic [31:0] val);
        bus.CDBRS_RS_en        = 1'b1;
        bus.CDBRS_RS_RoB_index = idx;
        bus.CDBRS_RS_value     = val;
    endtask

    task automatic lsb_cdb(input logic [7:0] idx, input logic [31:0] val);
        bus.CDBRS_LSB_en        = 1'b1;
        bus.CDBRS_LSB_RoB_index = idx;
        bus.CDBRS_LSB_value     = val;
    endtask

    task automatic chk_iss(input string tag, input logic [7:0] rob);
        chk({tag, "_en"}, 64'(bus.RSALU_en), 64'd1);
        chk({tag, "_rob"}, 64'(bus.RSALU_RoB_index), 64'(rob));
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.RoBRS_pre_judge = 1'b1;
        idle();
        ins(0, 0, 0, 0, ND, ND, 0, 0);
        bus.DPRS_en = 1'b0;
        bus.CDBRS_RS_RoB_index = '0; bus.CDBRS_RS_value = '0;
        bus.CDBRS_LSB_RoB_index = '0; bus.CDBRS_LSB_value = '0;
        step(); step();
        chk("rst_en", 64'(bus.RSALU_en), 64'd0);
        chk("rst_op", 64'(bus.RSALU_opcode), 64'd0);
        chk("rst_vj", 64'(bus.RSALU_Vj), 64'd0);
        chk("rst_pc", 64'(bus.RSALU_pc), 64'd0);
        chk("rst_full", 64'(bus.RSDP_full), 64'd0);
        rst = 1'b0;

        // ready insert: addi issues after the second edge, for one cycle
        ins(32'h100, addi, 5, 0, ND, ND, 3, 7);
        step(); idle();
        chk("rdy_ins_early", 64'(bus.RSALU_en), 64'd0);
        step();
        chk_iss("rdy_ins", 7);
        chk("rdy_ins_op", 64'(bus.RSALU_opcode), 64'd19);
        chk("rdy_ins_vj", 64'(bus.RSALU_Vj), 64'd5);
        chk("rdy_ins_imm", 64'(bus.RSALU_imm), 64'd3);
        chk("rdy_ins_pc", 64'(bus.RSALU_pc), 64'h100);
        step();
        chk("rdy_ins_once", 64'(bus.RSALU_en), 64'd0);
        chk("rdy_ins_hold_op", 64'(bus.RSALU_opcode), 64'd19);

        // dependency on tag 4, woken by RS port broadcast
        ins(32'h104, add, 0, 2, 9'd4, ND, 0, 8);
        step(); idle();
        chk("dep_wait0", 64'(bus.RSALU_en), 64'd0);
        step();
        chk("dep_wait1", 64'(bus.RSALU_en), 64'd0);
        rs_cdb(8'd4, 32'h10);
        step(); idle();
        chk("dep_bcast", 64'(bus.RSALU_en), 64'd0);
        step();
        chk_iss("dep", 8);
        chk("dep_vj", 64'(bus.RSALU_Vj), 64'h10);
        chk("dep_vk", 64'(bus.RSALU_Vk), 64'd2);
        chk("dep_op", 64'(bus.RSALU_opcode), 64'(add));
        step();

        // same-cycle capture from LSB port at insert
        ins(32'h108, sub, 1, 0, ND, 9'd9, 0, 9);
        lsb_cdb(8'd9, 32'hAB);
        step(); idle();
        step();
        chk_iss("same_cyc", 9);
        chk("same_cyc_vk", 64'(bus.RSALU_Vk), 64'hAB);
        chk("same_cyc_vj", 64'(bus.RSALU_Vj), 64'd1);
        step();

        // snoop: RS port wins double match on j; LSB port wakes k later
        ins(32'h10C, add, 0, 0, 9'd6, 9'd5, 0, 10);
        step(); idle();
        rs_cdb(8'd6, 32'h11);
        lsb_cdb(8'd6, 32'h22);
        step(); idle();
        chk("prec_wait", 64'(bus.RSALU_en), 64'd0);
        lsb_cdb(8'd5, 32'h33);
        step(); idle();
        chk("prec_wait2", 64'(bus.RSALU_en), 64'd0);
        step();
        chk_iss("prec", 10);
        chk("prec_vj", 64'(bus.RSALU_Vj), 64'h11);
        chk("prec_vk", 64'(bus.RSALU_Vk), 64'h33);
        step();

        // fill 15 entries blocked on tag 3, then drain in index order
        for (int i = 0; i < 15; i++) begin
            ins(32'(i), addi, 32'(i), 0, 9'd3, ND, 0, 8'(i));
            step();
            if (i == 13) chk("fill_14_full", 64'(bus.RSDP_full), 64'd0);
        end
        idle();
        chk("fill_15_full", 64'(bus.RSDP_full), 64'd1);
        rs_cdb(8'd3, 32'h77);
        step(); idle();
        chk("fill_bcast_en", 64'(bus.RSALU_en), 64'd0);
        chk("fill_bcast_full", 64'(bus.RSDP_full), 64'd1);
        for (int i = 0; i < 15; i++) begin
            step();
            chk_iss("drain", 8'(i));
            if (i == 0) begin
                chk("drain_full", 64'(bus.RSDP_full), 64'd0);
                chk("drain_vj", 64'(bus.RSALU_Vj), 64'h77);
            end
        end
        step();
        chk("drain_done", 64'(bus.RSALU_en), 64'd0);

        // flush: pending entries plus a ready one plus a same-cycle insert
        for (int i = 0; i < 4; i++) begin
            ins(32'h200, addi, 0, 0, 9'd3, ND, 0, 8'(20 + i));
            step();
        end
        ins(32'h210, addi, 0, 0, ND, ND, 0, 24);
        step();
        ins(32'h214, addi, 0, 0, ND, ND, 0, 25);
        bus.RoBRS_pre_judge = 1'b0;
        step();
        bus.RoBRS_pre_judge = 1'b1;
        idle();
        chk("flush_en", 64'(bus.RSALU_en), 64'd0);
        chk("flush_full", 64'(bus.RSDP_full), 64'd0);
        chk("flush_rob", 64'(bus.RSALU_RoB_index), 64'd0);
        rs_cdb(8'd3, 32'h1);
        step(); idle();
        chk("flush_after0", 64'(bus.RSALU_en), 64'd0);
        step();
        chk("flush_after1", 64'(bus.RSALU_en), 64'd0);
        step();
        chk("flush_after2", 64'(bus.RSALU_en), 64'd0);

        // rdy low holds RSALU_en and drops the insert presented meanwhile
        ins(32'h300, ori, 0, 0, ND, ND, 0, 40);
        step(); idle();
        step();
        chk_iss("rdy_pre", 40);
        rdy = 1'b0;
        ins(32'h304, ori, 0, 0, ND, ND, 0, 41);
        step();
        chk_iss("rdy_hold", 40);
        rdy = 1'b1;
        idle();
        step();
        chk("rdy_resume0", 64'(bus.RSALU_en), 64'd0);
        step();
        chk("rdy_dropped", 64'(bus.RSALU_en), 64'd0);

        // issue order: A in entry 3, B in entry 1, both on tag 2
        bus.RoBRS_pre_judge = 1'b0;
        step();
        bus.RoBRS_pre_judge = 1'b1;
        ins(0, add, 0, 0, 9'd12, ND, 0, 60); step();
        ins(0, add, 0, 0, 9'd13, ND, 0, 61); step();
        ins(0, add, 0, 0, 9'd12, ND, 0, 62); step();
        ins(0, add, 0, 0, 9'd2,  ND, 0, 50); step();
        idle();
        rs_cdb(8'd13, 32'h0);
        step(); idle();
        step();
        chk_iss("age_free1", 61);
        ins(0, add, 0, 0, 9'd2, ND, 0, 51);
        step(); idle();
        chk("age_wait", 64'(bus.RSALU_en), 64'd0);
        rs_cdb(8'd2, 32'h5);
        step(); idle();
        step();
`ifdef RS_AGE_ORDER_EN
        chk_iss("age_first", 50);
        step();
        chk_iss("age_second", 51);
`else
        chk_iss("idx_first", 51);
        step();
        chk_iss("idx_second", 50);
`endif
        step();
        chk("order_done", 64'(bus.RSALU_en), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
